// File: rtl/sys_defs.sv
// sys_defs: types shared by the dispatch, ROB and retire stages.
package sys_defs;
  localparam int XLEN   = 32;
  localparam int PHYS_W = 6;
  localparam int GHR_W  = 8;
  typedef logic [XLEN-1:0]   ADDR;
  typedef logic [GHR_W-1:0]  GHR;
  typedef logic [PHYS_W-1:0] PHYS_TAG;
  typedef logic [4:0]        ARCH_REG;
  typedef enum logic [3:0] {
    NO_ERROR            = 4'd0,
    INST_ADDR_MISALIGN  = 4'd1,
    INST_ACCESS_FAULT   = 4'd2,
    ILLEGAL_INST        = 4'd3,
    BREAKPOINT          = 4'd4,
    LOAD_ADDR_MISALIGN  = 4'd5,
    LOAD_ACCESS_FAULT   = 4'd6,
    STORE_ADDR_MISALIGN = 4'd7,
    STORE_ACCESS_FAULT  = 4'd8,
    ECALL               = 4'd9
  } EXCEPTION_CODE;
  typedef enum logic [1:0] {RUN, FLUSH, HALTED} RETIRE_STATE;
  typedef struct packed {
    logic          valid;
    logic          complete;
    ADDR           pc;
    ARCH_REG       arch_rd;
    PHYS_TAG       phys_rd;
    PHYS_TAG       prev_phys_rd;
    logic          uses_rd;
    logic          is_store;
    logic          is_branch;
    logic          pred_taken;
    ADDR           pred_target;
    logic          branch_taken;
    ADDR           branch_target;
    GHR            ghr_snapshot;
    logic          halt;
    EXCEPTION_CODE exception;
  } ROB_ENTRY;
  typedef struct packed {
    logic    valid;
    ARCH_REG addr;
    PHYS_TAG phys_reg;
  } ARCH_MAP_WRITE;
  // x0 is hardwired, so it never allocates nor frees a physical register
  function automatic logic writes_rd(ROB_ENTRY e);
    return e.uses_rd && e.arch_rd != '0;
  endfunction
endpackage

// File: rtl/retire_mispredict_check.sv
// retire_mispredict_check: per-entry branch mispredict flag and the correct redirect target.
module retire_mispredict_check
  import sys_defs::*;
(
  input  ROB_ENTRY entry,
  output logic     mispredict,
  output ADDR      redirect_pc
);
  always_comb begin
    mispredict  = entry.is_branch && (entry.branch_taken != entry.pred_taken ||
                  (entry.branch_taken && entry.branch_target != entry.pred_target));
    redirect_pc = entry.branch_taken ? entry.branch_target : entry.pc + ADDR'(4);
  end
endmodule

// File: rtl/stage_retire.sv
// stage_retire: in-order commit of the longest complete ROB head prefix, with flush and halt handling.
module stage_retire
  import sys_defs::*;
#(
  parameter  int N     = 2,
  parameter  int CNT_W = 32,
  localparam int CW    = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  ROB_ENTRY      rob_head_entries [N],
  input  logic [CW-1:0] rob_head_valid_count,
  input  logic          store_commit_ready,
  output logic [CW-1:0] retire_count,
  output logic [N-1:0]  free_valid,
  output PHYS_TAG       free_tag [N],
  output ARCH_MAP_WRITE arch_map_write [N],
  output logic          store_commit,
  output logic          flush_valid,
  output ADDR           flush_pc,
  output GHR            flush_ghr,
  output logic          halted,
  output EXCEPTION_CODE halt_exception,
  output logic [CNT_W-1:0] retired_insts
);
  RETIRE_STATE      state_q, state_d;
  logic             flush_valid_q, flush_valid_d;
  ADDR              flush_pc_q, flush_pc_d;
  GHR               flush_ghr_q, flush_ghr_d;
  logic             halted_q, halted_d;
  EXCEPTION_CODE    halt_exc_q, halt_exc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [N-1:0]     mp;
  ADDR              redirect [N];
  logic             stop, hit_halt, hit_mp;
  ADDR              hit_pc;
  GHR               hit_ghr;
  EXCEPTION_CODE    hit_exc;
  ROB_ENTRY         e;
  for (genvar i = 0; i < N; i++) begin : g_chk
    retire_mispredict_check u_chk (
      .entry       (rob_head_entries[i]),
      .mispredict  (mp[i]),
      .redirect_pc (redirect[i])
    );
  end
  // Scan oldest-first; a terminating lane retires and then blocks all younger lanes.
  always_comb begin
    retire_count = '0;
    free_valid   = '0;
    store_commit = 1'b0;
    hit_halt     = 1'b0;
    hit_mp       = 1'b0;
    hit_pc       = '0;
    hit_ghr      = '0;
    hit_exc      = NO_ERROR;
    e            = '0;
    stop         = !reset || state_q != RUN;
    for (int i = 0; i < N; i++) begin
      e                 = rob_head_entries[i];
      free_tag[i]       = '0;
      arch_map_write[i] = '0;
      if (i >= int'(rob_head_valid_count) || !e.valid || !e.complete ||
          (e.is_store && (store_commit || !store_commit_ready)))
        stop = 1'b1;
      if (!stop) begin
        retire_count = retire_count + CW'(1);
        store_commit = store_commit | e.is_store;
        if (writes_rd(e)) begin
          free_valid[i]     = 1'b1;
          free_tag[i]       = e.prev_phys_rd;
          arch_map_write[i] = '{valid: 1'b1, addr: e.arch_rd, phys_reg: e.phys_rd};
        end
        if (e.halt || e.exception != NO_ERROR) begin
          hit_halt = 1'b1;
          hit_exc  = e.exception;
          stop     = 1'b1;
        end else if (mp[i]) begin
          hit_mp  = 1'b1;
          hit_pc  = redirect[i];
          hit_ghr = e.ghr_snapshot;
          stop    = 1'b1;
        end
      end
    end
  end
  always_comb begin
    state_d       = hit_halt ? HALTED : hit_mp ? FLUSH : state_q == FLUSH ? RUN : state_q;
    flush_valid_d = hit_mp;
    flush_pc_d    = hit_mp ? hit_pc : flush_pc_q;
    flush_ghr_d   = hit_mp ? hit_ghr : flush_ghr_q;
    halted_d      = halted_q | hit_halt;
    halt_exc_d    = hit_halt ? hit_exc : halt_exc_q;
    retired_d     = retired_q + CNT_W'(retire_count);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      flush_valid_q <= 1'b0;
      flush_pc_q    <= '0;
      flush_ghr_q   <= '0;
      halted_q      <= 1'b0;
      halt_exc_q    <= NO_ERROR;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      flush_valid_q <= flush_valid_d;
      flush_pc_q    <= flush_pc_d;
      flush_ghr_q   <= flush_ghr_d;
      halted_q      <= halted_d;
      halt_exc_q    <= halt_exc_d;
      retired_q     <= retired_d;
    end
  end
  assign flush_valid    = flush_valid_q;
  assign flush_pc       = flush_pc_q;
  assign flush_ghr      = flush_ghr_q;
  assign halted         = halted_q;
  assign halt_exception = halt_exc_q;
  assign retired_insts  = retired_q;
endmodule
